// File: rtl/serial_adder_sub.sv
// serial_adder_sub: bit-serial add/subtract, one full-adder cell plus carry flop, LSB first.
module serial_adder_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s, c, last;
    assign s    = opa[0] ^ opb[0] ^ carry;
    assign c    = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
    assign last = cnt == CW'(WIDTH - 1);
    // Subtraction is a + ~b + 1: operand B is inverted at load and carry seeded with mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b ^ {WIDTH{mode}};
                        carry <= mode;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    sum   <= {s, sum[WIDTH-1:1]};
                    carry <= c;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cout     <= c;
                        overflow <= carry ^ c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub: scoreboard bench for WIDTH=8 directed vectors and a WIDTH=4 exhaustive sweep.
module tb_serial_adder_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, mode8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, cout8, ov8;
    logic       start4 = 1'b0, mode4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy4, done4, cout4, ov4;
    int cyc = 0;
    int pass_n = 0;
    int total_n = 0;
    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
        int         t0;
    } exp_t;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_adder_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
    );
    serial_adder_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ov4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total_n++;
                $display("FAIL dut8 done without pending op: got done=1 want 0");
            end else begin
                e = q8.pop_front();
                chk("dut8 sum", {24'd0, sum8}, {24'd0, e.s});
                chk("dut8 cout", {31'd0, cout8}, {31'd0, e.c});
                chk("dut8 overflow", {31'd0, ov8}, {31'd0, e.v});
                chk("dut8 latency", cyc - e.t0, 8);
                chk("dut8 busy at done", {31'd0, busy8}, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                total_n++;
                $display("FAIL dut4 done without pending op: got done=1 want 0");
            end else begin
                e = q4.pop_front();
                chk("dut4 sum", {28'd0, sum4}, {24'd0, e.s});
                chk("dut4 cout", {31'd0, cout4}, {31'd0, e.c});
                chk("dut4 overflow", {31'd0, ov4}, {31'd0, e.v});
                chk("dut4 latency", cyc - e.t0, 4);
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic [7:0] es, input logic ec, input logic ev);
        a8 = a;
        b8 = b;
        mode8 = m;
        start8 = 1'b1;
        q8.push_back('{s: es, c: ec, v: ev, t0: cyc + 1});
        tick();
        start8 = 1'b0;
        repeat (8) tick();
        tick();
    endtask

    task automatic chk_cleared(input string name);
        chk({name, " busy"}, {31'd0, busy8}, 0);
        chk({name, " done"}, {31'd0, done8}, 0);
        chk({name, " sum"}, {24'd0, sum8}, 0);
        chk({name, " cout"}, {31'd0, cout8}, 0);
        chk({name, " overflow"}, {31'd0, ov8}, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_cleared("reset");
        rst = 1'b0;
        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8(8'h07, 8'h07, 1'b1, 8'h00, 1'b1, 1'b0);
        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        // abort in the fourth RUN cycle: everything cleared, no done afterwards
        a8 = 8'h55;
        b8 = 8'h22;
        mode8 = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cleared("abort");
        repeat (12) tick();
        // start during RUN ignored; start held in the DONE cycle accepted
        a8 = 8'h10;
        b8 = 8'h20;
        mode8 = 1'b0;
        start8 = 1'b1;
        q8.push_back('{s: 8'h30, c: 1'b0, v: 1'b0, t0: cyc + 1});
        tick();
        start8 = 1'b0;
        repeat (2) tick();
        a8 = 8'h01;
        b8 = 8'h01;
        mode8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("busy while ignoring start", {31'd0, busy8}, 1);
        repeat (5) tick();
        chk("done in DONE cycle", {31'd0, done8}, 1);
        a8 = 8'h33;
        b8 = 8'h11;
        mode8 = 1'b0;
        start8 = 1'b1;
        q8.push_back('{s: 8'h44, c: 1'b0, v: 1'b0, t0: cyc + 1});
        tick();
        start8 = 1'b0;
        chk("back-to-back busy", {31'd0, busy8}, 1);
        chk("back-to-back done low", {31'd0, done8}, 0);
        repeat (8) tick();
        tick();
        // WIDTH=4 exhaustive sweep, each op issued in the previous op's DONE cycle
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    int bb, full, sx, sy, r;
                    bb = (m != 0) ? (((~y) & 15) + 1) : y;
                    full = x + bb;
                    sx = (x >= 8) ? x - 16 : x;
                    sy = (y >= 8) ? y - 16 : y;
                    r = (m != 0) ? sx - sy : sx + sy;
                    a4 = 4'(x);
                    b4 = 4'(y);
                    mode4 = m[0];
                    start4 = 1'b1;
                    q4.push_back('{s: 8'(full & 15), c: full[4], v: (r < -8 || r > 7), t0: cyc + 1});
                    tick();
                    start4 = 1'b0;
                    repeat (4) tick();
                end
            end
        end
        repeat (3) tick();
        chk("dut8 ops without done", q8.size(), 0);
        chk("dut4 ops without done", q4.size(), 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/serial_adder_sub.md
SERIAL_ADDER_SUB -- requirements
Module: serial_adder_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled on rising edge of clk.
REQ-005 Port: mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 Port: a  input  WIDTH  operand A; sampled with start.
REQ-007 Port: b  input  WIDTH  operand B; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when result becomes valid.
REQ-010 Port: sum  output  WIDTH  result, LSB first assembled; valid from done until next accepted start.
REQ-011 Port: cout  output  1  add: unsigned carry out; subtract: no-borrow flag (1 when a >= b unsigned).
REQ-012 Port: overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-013 Datapath SHALL be a single 1-bit full-adder cell plus carry flip-flop, processing one bit per cycle, LSB first.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: on start=1, latch a, b XOR {WIDTH{mode}}, set carry = mode, clear bit counter, assert busy, go RUN.
REQ-016 RUN: each cycle add bit 0 of operand shift registers with carry, shift result bit into sum MSB end, shift operands right, update carry, increment counter.
REQ-017 RUN: after the WIDTH-th bit, go DONE; busy drops and done rises on that same edge.
REQ-018 Latency: start sampled at edge E0 -> done=1 and busy=0 during the cycle following edge E0+WIDTH (exactly WIDTH cycles of busy).
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE, or RUN if start=1 in that cycle (back-to-back accepted).
REQ-020 start while in RUN SHALL be ignored; operands and mode of the running operation are unaffected.
REQ-021 cout SHALL equal final carry flip-flop value; overflow SHALL equal carry-into-MSB XOR carry-out, both registered when done rises.
REQ-022 sum, cout, overflow SHALL hold their values from done until the next accepted start; during RUN sum holds partial (shifting) contents and SHALL NOT be treated as valid.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-024 Bit counter SHALL be sized ceil(log2(WIDTH+1)) and never wrap during an operation.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, carry=0, counter=0.
REQ-026 rst SHALL take priority over start and abort any operation in RUN or DONE; no done pulse for an aborted operation.
REQ-027 First start SHALL be accepted on the first edge with rst=0.

Verification (WIDTH=8)
REQ-028 add 0x0F+0x01 -> after 8 busy cycles done pulse, sum=0x10, cout=0, overflow=0.
REQ-029 add 0xFF+0x01 -> sum=0x00, cout=1, overflow=0; add 0x7F+0x01 -> sum=0x80, cout=0, overflow=1.
REQ-030 sub 0x05-0x07 -> sum=0xFE, cout=0; sub 0x80-0x01 -> sum=0x7F, cout=1, overflow=1.
REQ-031 start 0x10+0x20, then start=1 with 0x01+0x01 at cycle 3 of RUN -> ignored, result 0x30; start held in DONE cycle -> second op accepted, busy high next cycle.
REQ-032 rst pulsed at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0, overflow=0; no done pulse follows.
REQ-033 Exhaustive sweep at WIDTH=4: all 256 (a,b) pairs x both modes checked against reference arithmetic, including latency = 4 cycles each.
